sdram_init_checker: RTL and testbench
=====================================

// Module: sdram_init_checker
// PURPOSE
//  Device-side receiver for the SDRAM power-up initialization command stream.
//  Samples {CS#,RAS#,CAS#,WE#}, bank and address each cycle and checks them
//  against the JEDEC init sequence: wait, PRE-all, N x AUTO REFRESH, MRS.
//  Decodes the programmed mode register and flags the first violation.
//  Placed between the init controller and the SDRAM pins, or in the bench.
// PARAMETERS
//  CNT_WAIT  10000  min NOP cycles after reset before first command
//  CNT_AR    8      min AUTO REFRESH count before MRS
//  TRP       2      min NOP cycles between PRE and next command
//  TRFC      7      min NOP cycles between AR and next command
//  TMRD      3      min NOP cycles after MRS before ready
// PORTS
//  chk_clk         in   1   clock, single domain
//  chk_rst         in   1   reset, synchronous, active-high
//  chk_cmd         in   4   {CS#,RAS#,CAS#,WE#}
//  chk_bank        in   2   bank address
//  chk_addr        in   13  address A12..A0
//  chk_ready       out  1   init sequence completed legally (sticky)
//  chk_err         out  1   violation detected (sticky)
//  chk_err_code    out  3   code of first violation
//  chk_ar_cnt      out  4   AUTO REFRESH commands accepted (saturates at 15)
//  chk_cas_lat     out  3   MRS A6..A4
//  chk_burst_type  out  1   MRS A3
//  chk_burst_len   out  3   MRS A2..A0 (raw)
//  chk_wr_single   out  1   MRS A9
// BEHAVIOUR
//  - Sync active-high reset, including mid-sequence: all outputs 0, FSM=WAIT, counters 0.
//  - Decode: CS#=1 or cmd 0111 = NOP; 0010 PRE; 0001 AR; 0000 MRS; other = OTHER.
//  - Outputs registered: input sampled at cycle t is reflected at cycle t+1.
//  - gap_cnt: counts consecutive NOPs, cleared on any non-NOP command.
//    Wait counter $clog2(CNT_WAIT+1) bits, saturating.
//  - FSM states:
//    WAIT: count NOPs; non-NOP with count<CNT_WAIT -> err 1;
//      PRE once count>=CNT_WAIT -> TRP; other command -> err 4.
//    TRP: PRE needs A10=1, else err 2. Non-NOP with gap<TRP -> err 3.
//      Non-NOP other than AR -> err 4. AR -> TRFC, ar_cnt+1.
//    TRFC: non-NOP with gap<TRFC -> err 3. AR -> TRFC, ar_cnt+1;
//      extra ARs beyond CNT_AR are legal. MRS with ar_cnt<CNT_AR -> err 5.
//      Other command -> err 4.
//    MRS accept: needs bank=00, A12..A10=000, A8..A7=00, A6..A4 in {010,011},
//      A2..A0 in {000,001,010,011,111}; else err 6. On accept, latch the
//      mode fields -> TMRD.
//    TMRD: non-NOP before TMRD NOPs -> err 3. After the TMRD-th NOP -> READY.
//    READY: chk_ready=1; all later commands are ignored; mode fields hold.
//    ERROR: chk_err=1; chk_err_code holds the first code; exit only by reset.
//  - NOP dwell in TRP/TRFC/TMRD is unbounded (no max-time check).
//  - Exactly one command per cycle. Error checks have priority, in code order 1..6.
//  - Mode outputs are 0 until MRS is accepted. ar_cnt is frozen in READY/ERROR.
// TESTING
//  1 Golden: 10000 NOP, PRE addr 1FFF, 2 NOP, 8x(AR, 7 NOP), MRS bank 0 addr 0037,
//    3 NOP -> ready=1 the cycle after the 3rd NOP; cas_lat=3, burst_len=7,
//    burst_type=0, ar_cnt=8, err=0.
//  2 PRE after 9999 NOPs -> err=1, code=1; ready stays 0 for the remaining stream.
//  3 Golden, but AR after 1 NOP following PRE -> code 3. PRE with addr 0000 -> code 2.
//  4 MRS after only 7 ARs -> code 5. MRS addr 0047 (CL=4) -> code 6, mode outputs stay 0.
//  5 Deselect (CS#=1, other bits 0) during waits counts as NOP -> golden still passes.
//    Reset asserted during TRFC -> all outputs 0; golden rerun -> ready=1.
//  6 After ready, issue PRE/AR/OTHER -> ready stays 1, err stays 0, fields unchanged.

Source files
------------

// File: rtl/sdram_init_checker.sv
// sdram_init_checker: device-side monitor for the SDRAM power-up init command stream.
// Tracks wait / PRE-all / AUTO REFRESH / MRS ordering and timing, flags the first violation.
module sdram_init_checker #(
    parameter int CNT_WAIT = 10000,
    parameter int CNT_AR   = 8,
    parameter int TRP      = 2,
    parameter int TRFC     = 7,
    parameter int TMRD     = 3
) (
    input  logic        chk_clk,
    input  logic        chk_rst,
    input  logic [3:0]  chk_cmd,
    input  logic [1:0]  chk_bank,
    input  logic [12:0] chk_addr,
    output logic        chk_ready,
    output logic        chk_err,
    output logic [2:0]  chk_err_code,
    output logic [3:0]  chk_ar_cnt,
    output logic [2:0]  chk_cas_lat,
    output logic        chk_burst_type,
    output logic [2:0]  chk_burst_len,
    output logic        chk_wr_single
);

    localparam int GW = $clog2(CNT_WAIT + 1);
    localparam logic [GW-1:0] WAIT_L  = GW'(CNT_WAIT);
    localparam logic [GW-1:0] TRP_L   = GW'(TRP);
    localparam logic [GW-1:0] TRFC_L  = GW'(TRFC);
    localparam logic [GW-1:0] TMRD_M1 = GW'(TMRD - 1);
    localparam logic [3:0]    AR_L    = 4'(CNT_AR);

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_EARLY = 3'd1;
    localparam logic [2:0] E_PREA  = 3'd2;
    localparam logic [2:0] E_GAP   = 3'd3;
    localparam logic [2:0] E_ORDER = 3'd4;
    localparam logic [2:0] E_ARCNT = 3'd5;
    localparam logic [2:0] E_MODE  = 3'd6;

    typedef enum logic [2:0] {
        S_WAIT,
        S_TRP,
        S_TRFC,
        S_TMRD,
        S_READY,
        S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap_cnt;
    logic [3:0]      ar_cnt;
    logic [2:0]      err_code;
    logic [2:0]      err_nxt;
    logic            ar_inc;
    logic            mrs_acc;
    logic            is_nop, is_pre, is_ar, is_mrs;
    logic            mode_ok;
    logic [2:0]      cas_q, bl_q;
    logic            bt_q, ws_q;

    assign is_nop = chk_cmd[3] || (chk_cmd == 4'b0111);
    assign is_pre = (chk_cmd == 4'b0010);
    assign is_ar  = (chk_cmd == 4'b0001);
    assign is_mrs = (chk_cmd == 4'b0000);

    // CL in {2,3} means A6=0,A5=1; BL in {1,2,4,8,page} means A2=0 or A1..A0=11.
    assign mode_ok = (chk_bank == 2'b00) && (chk_addr[12:10] == 3'b000) &&
                     (chk_addr[8:7] == 2'b00) && (chk_addr[6:5] == 2'b01) &&
                     (!chk_addr[2] || (chk_addr[1:0] == 2'b11));

    always_ff @(posedge chk_clk) begin
        if (chk_rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = E_NONE;
        ar_inc    = 1'b0;
        mrs_acc   = 1'b0;
        case (state)
            S_WAIT: if (!is_nop) begin
                if (gap_cnt < WAIT_L)   err_nxt = E_EARLY;
                else if (!is_pre)       err_nxt = E_ORDER;
                else if (!chk_addr[10]) err_nxt = E_PREA;
                else                    state_nxt = S_TRP;
            end
            S_TRP: if (!is_nop) begin
                if (gap_cnt < TRP_L) err_nxt = E_GAP;
                else if (is_ar) begin
                    ar_inc    = 1'b1;
                    state_nxt = S_TRFC;
                end else                err_nxt = E_ORDER;
            end
            S_TRFC: if (!is_nop) begin
                if (gap_cnt < TRFC_L)   err_nxt = E_GAP;
                else if (is_ar)         ar_inc  = 1'b1;
                else if (!is_mrs)       err_nxt = E_ORDER;
                else if (ar_cnt < AR_L) err_nxt = E_ARCNT;
                else if (!mode_ok)      err_nxt = E_MODE;
                else begin
                    mrs_acc   = 1'b1;
                    state_nxt = S_TMRD;
                end
            end
            // gap_cnt still holds the count before this cycle's NOP is added.
            S_TMRD: begin
                if (!is_nop)                  err_nxt   = E_GAP;
                else if (gap_cnt >= TMRD_M1)  state_nxt = S_READY;
            end
            default: ;
        endcase
        if (err_nxt != E_NONE) state_nxt = S_ERROR;
    end

    always_comb begin
        chk_ready = (state == S_READY);
        chk_err   = (state == S_ERROR);
    end

    always_ff @(posedge chk_clk) begin
        if (chk_rst) begin
            gap_cnt  <= '0;
            ar_cnt   <= '0;
            err_code <= '0;
            cas_q    <= '0;
            bt_q     <= 1'b0;
            bl_q     <= '0;
            ws_q     <= 1'b0;
        end else begin
            if (!is_nop)              gap_cnt <= '0;
            else if (gap_cnt != '1)   gap_cnt <= gap_cnt + GW'(1);
            if (ar_inc && (ar_cnt != 4'hF)) ar_cnt <= ar_cnt + 4'd1;
            if (err_nxt != E_NONE)    err_code <= err_nxt;
            if (mrs_acc) begin
                cas_q <= chk_addr[6:4];
                bt_q  <= chk_addr[3];
                bl_q  <= chk_addr[2:0];
                ws_q  <= chk_addr[9];
            end
        end
    end

    assign chk_err_code   = err_code;
    assign chk_ar_cnt     = ar_cnt;
    assign chk_cas_lat    = cas_q;
    assign chk_burst_type = bt_q;
    assign chk_burst_len  = bl_q;
    assign chk_wr_single  = ws_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Bench for sdram_init_checker: a full-size and a short-wait instance share one command stream
// and are compared against an event-level reference model, constant vectors and a scenario table.
module tb_sdram_init_checker;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_DES = 4'b1000;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_AR  = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_OTH = 4'b0011;
    localparam int M_AR = 8, M_TRP = 2, M_TRFC = 7, M_TMRD = 3;

    logic        chk_clk = 1'b0;
    logic        chk_rst = 1'b1;
    logic [3:0]  chk_cmd = C_NOP;
    logic [1:0]  chk_bank = '0;
    logic [12:0] chk_addr = '0;

    logic b_ready, b_err, b_bt, b_ws, s_ready, s_err, s_bt, s_ws;
    logic [2:0] b_code, b_cas, b_bl, s_code, s_cas, s_bl;
    logic [3:0] b_ar, s_ar;
    logic [16:0] b_vec, s_vec;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 chk_clk = ~chk_clk;

    sdram_init_checker u_big (
        .chk_clk(chk_clk), .chk_rst(chk_rst), .chk_cmd(chk_cmd), .chk_bank(chk_bank),
        .chk_addr(chk_addr), .chk_ready(b_ready), .chk_err(b_err), .chk_err_code(b_code),
        .chk_ar_cnt(b_ar), .chk_cas_lat(b_cas), .chk_burst_type(b_bt),
        .chk_burst_len(b_bl), .chk_wr_single(b_ws)
    );

    sdram_init_checker #(.CNT_WAIT(20)) u_sml (
        .chk_clk(chk_clk), .chk_rst(chk_rst), .chk_cmd(chk_cmd), .chk_bank(chk_bank),
        .chk_addr(chk_addr), .chk_ready(s_ready), .chk_err(s_err), .chk_err_code(s_code),
        .chk_ar_cnt(s_ar), .chk_cas_lat(s_cas), .chk_burst_type(s_bt),
        .chk_burst_len(s_bl), .chk_wr_single(s_ws)
    );

    assign b_vec = {b_ready, b_err, b_code, b_ar, b_cas, b_bt, b_bl, b_ws};
    assign s_vec = {s_ready, s_err, s_code, s_ar, s_cas, s_bt, s_bl, s_ws};

    // Reference model: tracks which milestones have been seen and the NOP run length.
    typedef struct {
        int         wait_n;
        int         nops;
        bit         pre_seen;
        int         ars;
        bit         mrs_seen;
        bit         ready;
        int         code;
        logic [2:0] cas;
        logic       bt;
        logic [2:0] bl;
        logic       ws;
    } model_t;

    model_t m_big, m_sml;

    function automatic bit legal_mode(logic [1:0] b, logic [12:0] a);
        int cl = int'(a[6:4]);
        int bl = int'(a[2:0]);
        return (b == 0) && (a[12:10] == 0) && (a[8:7] == 0) && (cl == 2 || cl == 3) &&
               (bl <= 3 || bl == 7);
    endfunction

    function automatic model_t mstep(model_t m, bit r, logic [3:0] c, logic [1:0] b,
                                     logic [12:0] a);
        int code = 0;
        int need;
        bit nop = c[3] || (c == C_NOP);
        if (r) begin
            m.nops = 0; m.pre_seen = 0; m.ars = 0; m.mrs_seen = 0; m.ready = 0; m.code = 0;
            m.cas = '0; m.bt = 1'b0; m.bl = '0; m.ws = 1'b0;
            return m;
        end
        if (m.ready || m.code != 0) return m;
        if (nop) begin
            m.nops++;
            if (m.mrs_seen && m.nops >= M_TMRD) m.ready = 1;
            return m;
        end
        if (!m.pre_seen) begin
            if (m.nops < m.wait_n)  code = 1;
            else if (c != C_PRE)    code = 4;
            else if (!a[10])        code = 2;
            else                    m.pre_seen = 1;
        end else if (m.mrs_seen) begin
            code = 3;
        end else begin
            need = (m.ars == 0) ? M_TRP : M_TRFC;
            if (m.nops < need)                 code = 3;
            else if (c == C_AR)                m.ars++;
            else if (c == C_MRS && m.ars > 0) begin
                if (m.ars < M_AR)              code = 5;
                else if (!legal_mode(b, a))    code = 6;
                else begin
                    m.mrs_seen = 1;
                    m.cas = a[6:4]; m.bt = a[3]; m.bl = a[2:0]; m.ws = a[9];
                end
            end else                           code = 4;
        end
        m.code = code;
        m.nops = 0;
        return m;
    endfunction

    function automatic logic [16:0] mvec(model_t m);
        logic [3:0] ar = (m.ars > 15) ? 4'hF : 4'(m.ars);
        return {m.ready, m.code != 0, 3'(m.code), ar, m.cas, m.bt, m.bl, m.ws};
    endfunction

    function automatic logic [16:0] cvec(bit rdy, int code, int ar, int cas, bit bt, int bl,
                                         bit ws);
        return {rdy, code != 0, 3'(code), 4'(ar), 3'(cas), bt, 3'(bl), ws};
    endfunction

    task automatic cmp(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %05h (rdy,err,code,ar,cl,bt,bl,ws) expected %05h",
                      name, act, exp);
    endtask

    task automatic tick(input logic [3:0] c, input logic [1:0] b = '0,
                        input logic [12:0] a = '0, input bit r = 1'b0, input bit chk = 1'b1);
        @(negedge chk_clk);
        chk_cmd = c; chk_bank = b; chk_addr = a; chk_rst = r;
        @(posedge chk_clk);
        #1;
        m_big = mstep(m_big, r, c, b, a);
        m_sml = mstep(m_sml, r, c, b, a);
        if (chk) begin
            cmp("model_big", b_vec, mvec(m_big));
            cmp("model_sml", s_vec, mvec(m_sml));
        end
    endtask

    function automatic logic [3:0] idle(bit des, int i);
        return (des && (i % 2 == 0)) ? C_DES : C_NOP;
    endfunction

    task automatic run_seq(input int wait_n, input logic [12:0] pre_a, input int gap,
                           input int n_ar, input int ar_gap, input logic [1:0] mb,
                           input logic [12:0] ma, input int tmrd_n, input bit des);
        for (int i = 0; i < wait_n; i++) tick(idle(des, i), 2'd0, 13'd0, 1'b0, i == wait_n - 1);
        tick(C_PRE, 2'd0, pre_a);
        for (int i = 0; i < gap; i++) tick(idle(des, i));
        for (int k = 0; k < n_ar; k++) begin
            tick(C_AR);
            for (int i = 0; i < ar_gap; i++) tick(idle(des, i));
        end
        tick(C_MRS, mb, ma);
        for (int i = 0; i < tmrd_n; i++) tick(idle(des, i));
    endtask

    typedef struct {
        int          wait_n;
        logic [12:0] pre_a;
        int          gap;
        int          n_ar;
        int          ar_gap;
        logic [1:0]  mb;
        logic [12:0] ma;
        int          tmrd_n;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        m_big = '{wait_n: 10000, default: 0};
        m_sml = '{wait_n: 20, default: 0};

        // Short-wait scenarios; expectations are for the CNT_WAIT=20 instance.
        tbl[0]  = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 3, cvec(1, 0, 8, 3, 0, 7, 0)};
        tbl[1]  = '{20, 13'h1FFF, 1, 8, 7, 2'd0, 13'h0037, 3, cvec(0, 3, 0, 0, 0, 0, 0)};
        tbl[2]  = '{20, 13'h0000, 2, 8, 7, 2'd0, 13'h0037, 3, cvec(0, 2, 0, 0, 0, 0, 0)};
        tbl[3]  = '{20, 13'h1FFF, 2, 7, 7, 2'd0, 13'h0037, 3, cvec(0, 5, 7, 0, 0, 0, 0)};
        tbl[4]  = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0047, 3, cvec(0, 6, 8, 0, 0, 0, 0)};
        tbl[5]  = '{20, 13'h1FFF, 2, 8, 7, 2'd1, 13'h0037, 3, cvec(0, 6, 8, 0, 0, 0, 0)};
        tbl[6]  = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0237, 3, cvec(1, 0, 8, 3, 0, 7, 1)};
        tbl[7]  = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0034, 3, cvec(0, 6, 8, 0, 0, 0, 0)};
        tbl[8]  = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h00B7, 3, cvec(0, 6, 8, 0, 0, 0, 0)};
        tbl[9]  = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0029, 3, cvec(1, 0, 8, 2, 1, 1, 0)};
        tbl[10] = '{19, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 3, cvec(0, 1, 0, 0, 0, 0, 0)};
        tbl[11] = '{20, 13'h1FFF, 2, 10, 7, 2'd0, 13'h0037, 3, cvec(1, 0, 10, 3, 0, 7, 0)};
        tbl[12] = '{20, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 2, cvec(0, 0, 8, 3, 0, 7, 0)};
        tbl[13] = '{20, 13'h1FFF, 2, 16, 7, 2'd0, 13'h0037, 3, cvec(1, 0, 15, 3, 0, 7, 0)};
        tbl[14] = '{20, 13'h1FFF, 2, 8, 6, 2'd0, 13'h0037, 3, cvec(0, 3, 1, 0, 0, 0, 0)};
        tbl[15] = '{20, 13'h1FFF, 2, 0, 7, 2'd0, 13'h0037, 3, cvec(0, 4, 0, 0, 0, 0, 0)};

        tick(C_NOP, 2'd0, 13'd0, 1'b1);
        tick(C_NOP, 2'd0, 13'd0, 1'b1);
        cmp("reset_big", b_vec, '0);
        cmp("reset_sml", s_vec, '0);

        // Full golden sequence; ready must appear only after the third post-MRS NOP.
        run_seq(10000, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 2, 1'b0);
        cmp("golden_2nd_tmrd_nop", b_vec, cvec(0, 0, 8, 3, 0, 7, 0));
        tick(C_NOP);
        cmp("golden_ready", b_vec, cvec(1, 0, 8, 3, 0, 7, 0));

        tick(C_PRE, 2'd0, 13'h1FFF);
        tick(C_AR);
        tick(C_OTH, 2'd3, 13'h1234);
        tick(C_MRS, 2'd0, 13'h0047);
        cmp("after_ready_ignored", b_vec, cvec(1, 0, 8, 3, 0, 7, 0));

        tick(C_NOP, 2'd0, 13'd0, 1'b1);
        run_seq(9999, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 3, 1'b0);
        cmp("early_pre", b_vec, cvec(0, 1, 0, 0, 0, 0, 0));

        tick(C_NOP, 2'd0, 13'd0, 1'b1);
        run_seq(10000, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 3, 1'b1);
        cmp("deselect_golden", b_vec, cvec(1, 0, 8, 3, 0, 7, 0));

        tick(C_NOP, 2'd0, 13'd0, 1'b1);
        for (int i = 0; i < 10000; i++) tick(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0);
        tick(C_PRE, 2'd0, 13'h0400);
        tick(C_NOP); tick(C_NOP);
        tick(C_AR);
        tick(C_NOP); tick(C_NOP); tick(C_NOP);
        cmp("in_trfc", b_vec, cvec(0, 0, 1, 0, 0, 0, 0));
        tick(C_NOP, 2'd0, 13'd0, 1'b1);
        cmp("reset_mid_trfc", b_vec, '0);
        run_seq(10000, 13'h1FFF, 2, 8, 7, 2'd0, 13'h0037, 3, 1'b0);
        cmp("golden_rerun", b_vec, cvec(1, 0, 8, 3, 0, 7, 0));

        for (int i = 0; i < 16; i++) begin
            tick(C_NOP, 2'd0, 13'd0, 1'b1);
            run_seq(tbl[i].wait_n, tbl[i].pre_a, tbl[i].gap, tbl[i].n_ar, tbl[i].ar_gap,
                    tbl[i].mb, tbl[i].ma, tbl[i].tmrd_n, 1'b0);
            cmp($sformatf("tbl%0d", i), s_vec, tbl[i].exp);
        end

        // Randomised near-legal sequences followed by random trailing commands.
        for (int e = 0; e < 40; e++) begin
            logic [12:0] pa, ma;
            logic [1:0]  mb;
            pa = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 4) != 0) pa[10] = 1'b1;
            ma = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 2) != 0) ma = ma & 13'h027F;
            mb = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            tick(C_NOP, 2'd0, 13'd0, 1'b1);
            run_seq($urandom_range(18, 22), pa, $urandom_range(1, 3), $urandom_range(6, 10),
                    $urandom_range(6, 8), mb, ma, $urandom_range(1, 4),
                    1'($urandom_range(0, 1)));
            for (int k = 0; k < 6; k++)
                tick(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     13'($urandom_range(0, 8191)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
